dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single data RAM port: requester 0 is the CPU data path, requester 1 is the DMA/VGA framebuffer engine.
- Sits between the system bus memory-side outputs / DMA engine and the RAM instance.
- Round-robin grant with bounded lock (burst) support.
- Tracks read latency so each read response returns to the requester that issued it.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/rd_tag_pipe.sv | 31 +++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus: RAM access-type encoding,
// requester ids and the read-response tag carried down the latency pipe.
package mem_bus_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register of read tags; the tag leaving the last stage
// lines up with the RAM read data for that access.
module rd_tag_pipe
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clock,
  input  logic    flush_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clock) begin
    if (!flush_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded locking in front of the single data RAM
// port; read responses are steered back to the issuing requester.
module dmem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_LOCK     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [2:0]            type0,
  input  logic [2:0]            type1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [2:0]            mem_access_type,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  logic       last_owner;
  logic       lock_valid;
  logic       lock_owner;
  logic [7:0] lock_cnt;

  logic [1:0] req_vec;
  logic       grant_any;
  logic       grant_id;
  logic       grant_lock;
  logic       grant_we;
  logic       lock_limit;
  rd_tag_t    tag_in;
  rd_tag_t    tag_out;

  assign req_vec = {req1, req0};

  always_comb begin
    grant_any = 1'b0;
    grant_id  = REQ_CPU;
    if (reset) begin
      if (lock_valid && req_vec[lock_owner]) begin
        grant_any = 1'b1;
        grant_id  = lock_owner;
      end else if (req0 && req1) begin
        grant_any = 1'b1;
        grant_id  = ~last_owner;
      end else if (req0) begin
        grant_any = 1'b1;
        grant_id  = REQ_CPU;
      end else if (req1) begin
        grant_any = 1'b1;
        grant_id  = REQ_DMA;
      end
    end
  end

  assign gnt0 = grant_any && (grant_id == REQ_CPU);
  assign gnt1 = grant_any && (grant_id == REQ_DMA);

  // Requester 0 drives the port whenever requester 1 is not granted.
  assign mem_addr        = gnt1 ? addr1  : addr0;
  assign mem_write_data  = gnt1 ? wdata1 : wdata0;
  assign mem_access_type = gnt1 ? type1  : type0;
  assign grant_we        = gnt1 ? we1    : we0;
  assign grant_lock      = gnt1 ? lock1  : lock0;
  assign mem_write_en    = grant_any && grant_we;

  // Grant at count MAX_LOCK-1 is the last one the current lock may take.
  assign lock_limit = lock_valid && (lock_owner == grant_id) &&
                      (lock_cnt == 8'(MAX_LOCK - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_owner <= REQ_DMA;
      lock_valid <= 1'b0;
      lock_owner <= REQ_CPU;
      lock_cnt   <= 8'd0;
    end else if (grant_any) begin
      last_owner <= grant_id;
      if (grant_lock && !lock_limit) begin
        lock_valid <= 1'b1;
        lock_owner <= grant_id;
        lock_cnt   <= (lock_valid && lock_owner == grant_id) ? lock_cnt + 8'd1 : 8'd1;
      end else begin
        lock_valid <= 1'b0;
        lock_cnt   <= 8'd0;
      end
    end else begin
      // No grant means the locked owner (if any) dropped its request.
      lock_valid <= 1'b0;
      lock_cnt   <= 8'd0;
    end
  end

  assign tag_in = '{valid: grant_any && !grant_we, id: grant_id};

  rd_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_tag_pipe (
    .clock  (clock),
    .flush_n(reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign rvalid0 = tag_out.valid && (tag_out.id == REQ_CPU);
  assign rvalid1 = tag_out.valid && (tag_out.id == REQ_DMA);
  assign rdata0  = mem_read_data;
  assign rdata1  = mem_read_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a READ_LATENCY=1 instance with a RAM model,
// plus a READ_LATENCY=2 instance on the same stimulus for the reset-flush case.
module tb_dmem_arbiter;
  import mem_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  type0, type1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1, mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_en;
  logic [2:0]  mem_access_type;

  logic        g2_0, g2_1, rv2_0, rv2_1, m2_we;
  logic [31:0] rd2_0, rd2_1, m2_addr, m2_wdata, mem_read_data2;
  logic [2:0]  m2_type;

  logic        pre_en;
  logic [31:0] pre_addr, pre_data;
  logic [31:0] ram [64];
  logic [31:0] rd_q1, rd_q2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.READ_LATENCY(1), .MAX_LOCK(8)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
    .type0(type0), .type1(type1), .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0),
    .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_access_type(mem_access_type), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.READ_LATENCY(2), .MAX_LOCK(8)) dut2 (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
    .type0(type0), .type1(type1), .gnt0(g2_0), .gnt1(g2_1), .rvalid0(rv2_0),
    .rvalid1(rv2_1), .rdata0(rd2_0), .rdata1(rd2_1), .mem_addr(m2_addr),
    .mem_write_en(m2_we), .mem_write_data(m2_wdata),
    .mem_access_type(m2_type), .mem_read_data(mem_read_data2)
  );

  function automatic logic [31:0] load(input logic [31:0] w, input logic [1:0] off,
                                       input logic [2:0] t);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (t)
      LB:      return {{24{s[7]}}, s[7:0]};
      LH:      return {{16{s[15]}}, s[15:0]};
      LBU:     return {24'd0, s[7:0]};
      LHU:     return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store(input logic [31:0] w, input logic [1:0] off,
                                        input logic [2:0] t, input logic [31:0] d);
    logic [31:0] m;
    case (t)
      3'b000:  m = 32'h0000_00FF << {off, 3'b000};
      3'b001:  m = 32'h0000_FFFF << {off, 3'b000};
      default: m = 32'hFFFF_FFFF;
    endcase
    return (w & ~m) | ((d << {off, 3'b000}) & m);
  endfunction

  always @(posedge clock) begin
    rd_q1 <= load(ram[mem_addr[7:2]], mem_addr[1:0], mem_access_type);
    rd_q2 <= rd_q1;
    if (pre_en) ram[pre_addr[7:2]] <= pre_data;
    else if (mem_write_en)
      ram[mem_addr[7:2]] <= store(ram[mem_addr[7:2]], mem_addr[1:0], mem_access_type,
                                  mem_write_data);
  end

  assign mem_read_data  = rd_q1;
  assign mem_read_data2 = rd_q2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    tick();
    tick();
    reset = 1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1;
    tick();
    pre_en = 0;
  endtask

  task automatic test_reset();
    reset = 0; idle(); req0 = 1;
    tick(); tick();
    tests++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      fails++; $display("FAIL reset_gnt: gnt0=%b gnt1=%b want 0 0", gnt0, gnt1);
    end
    tests++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      fails++; $display("FAIL reset_rvalid: rvalid0=%b rvalid1=%b want 0 0", rvalid0, rvalid1);
    end
    reset = 1; req0 = 0; addr0 = 32'h44;
    #1;
    tests++;
    if (mem_write_en !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      fails++; $display("FAIL idle_port: we=%b gnt=%b%b want 0 00", mem_write_en, gnt0, gnt1);
    end
    tests++;
    if (mem_addr !== 32'h44) begin
      fails++; $display("FAIL idle_addr: got %h want 00000044", mem_addr);
    end
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 32'h10; type0 = LW;
    #1;
    tests++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 32'h10 || mem_write_en !== 1'b0) begin
      fails++;
      $display("FAIL single_gnt: gnt=%b%b addr=%h we=%b want 01 00000010 0",
               gnt1, gnt0, mem_addr, mem_write_en);
    end
    tick(); req0 = 0; #1;
    tests++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin
      fails++;
      $display("FAIL single_rdata: rvalid0=%b rdata0=%h rvalid1=%b want 1 deadbeef 0",
               rvalid0, rdata0, rvalid1);
    end
    tick();
    tests++;
    if (rvalid0 !== 1'b0) begin
      fails++; $display("FAIL single_once: rvalid0=%b want 0", rvalid0);
    end
  endtask

  task automatic test_alternate();
    logic        e0;
    logic [31:0] ed;
    do_reset();
    addr0 = 32'h10; addr1 = 32'h14; type0 = LW; type1 = LW;
    for (int k = 0; k < 5; k++) begin
      req0 = (k < 4); req1 = (k < 4);
      #1;
      if (k < 4) begin
        e0 = (k % 2 == 0);
        tests++;
        if (gnt0 !== e0 || gnt1 !== !e0) begin
          fails++; $display("FAIL alt_gnt[%0d]: gnt0=%b gnt1=%b want %b %b", k, gnt0, gnt1, e0, !e0);
        end
      end
      if (k > 0) begin
        e0 = ((k - 1) % 2 == 0);
        ed = e0 ? 32'hDEADBEEF : 32'h11112222;
        tests++;
        if (rvalid0 !== e0 || rvalid1 !== !e0 || rdata0 !== ed) begin
          fails++;
          $display("FAIL alt_rsp[%0d]: rvalid=%b%b rdata=%h want %b%b %h",
                   k, rvalid1, rvalid0, rdata0, !e0, e0, ed);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    logic e1;
    addr1 = 32'h30; we1 = 1; wdata1 = 0; type1 = LW;
    addr0 = 32'h34; we0 = 1; wdata0 = 0; type0 = LW;
    for (int k = 0; k < 11; k++) begin
      req1 = 1; lock1 = (k < 9); req0 = (k >= 1);
      #1;
      e1 = (k < 8) || (k == 9);
      tests++;
      if (gnt1 !== e1 || gnt0 !== !e1) begin
        fails++; $display("FAIL lock_gnt[%0d]: gnt0=%b gnt1=%b want %b %b", k, gnt0, gnt1, !e1, e1);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_write_then_read();
    preload(32'h20, 32'h12345600);
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'hAB; type1 = LB;
    req0 = 1; we0 = 0; addr0 = 32'h20; type0 = LBU;
    #1;
    tests++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_write_en !== 1'b1 || mem_write_data !== 32'hAB) begin
      fails++;
      $display("FAIL wr_gnt: gnt=%b%b we=%b wdata=%h want 10 1 000000ab",
               gnt1, gnt0, mem_write_en, mem_write_data);
    end
    tick(); req1 = 0; we1 = 0; #1;
    tests++;
    if (gnt0 !== 1'b1 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      fails++;
      $display("FAIL wr_norsp: gnt0=%b rvalid=%b%b want 1 00", gnt0, rvalid1, rvalid0);
    end
    tick(); req0 = 0; #1;
    tests++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hAB || rvalid1 !== 1'b0) begin
      fails++;
      $display("FAIL rd_after_wr: rvalid0=%b rdata0=%h rvalid1=%b want 1 000000ab 0",
               rvalid0, rdata0, rvalid1);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 32'h10; type0 = LW;
    #1;
    tests++;
    if (g2_0 !== 1'b1) begin
      fails++; $display("FAIL flush_gnt: gnt0=%b want 1", g2_0);
    end
    tick(); reset = 0; #1;
    tests++;
    if (g2_0 !== 1'b0 || g2_1 !== 1'b0) begin
      fails++; $display("FAIL flush_gnt_low: gnt=%b%b want 00", g2_1, g2_0);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if (rv2_0 !== 1'b0 || rv2_1 !== 1'b0) begin
        fails++; $display("FAIL flush_rvalid[%0d]: rvalid=%b%b want 00", k, rv2_1, rv2_0);
      end
    end
    reset = 1; req0 = 1; req1 = 1; we1 = 0; addr1 = 32'h14; type1 = LW;
    #1;
    tests++;
    if (g2_0 !== 1'b1 || g2_1 !== 1'b0) begin
      fails++; $display("FAIL flush_tie: gnt=%b%b want 01", g2_1, g2_0);
    end
    tick(); idle(); tick(); tick();
  endtask

  task automatic test_lock_drop();
    do_reset();
    req0 = 1; lock0 = 1; we0 = 1; addr0 = 32'h38; wdata0 = 0;
    req1 = 1; lock1 = 0; we1 = 1; addr1 = 32'h3C; wdata1 = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
        fails++; $display("FAIL lockdrop_hold[%0d]: gnt=%b%b want 01", k, gnt1, gnt0);
      end
      tick();
    end
    req0 = 0;
    #1;
    tests++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      fails++; $display("FAIL lockdrop_release: gnt=%b%b want 10", gnt1, gnt0);
    end
    tick(); idle(); tick();
  endtask

  initial begin
    reset = 0; pre_en = 0; pre_addr = 0; pre_data = 0;
    idle();
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; type0 = LW; type1 = LW;
    tick();
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h14, 32'h11112222);
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_write_then_read();
    test_reset_inflight();
    test_lock_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
